// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b, one bit per clock, LSB first.
// Operands load on a start handshake; the result is flagged by a one-cycle done pulse.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] differ,
   output logic             barrow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sr;
   logic             br;
   logic [CW-1:0]    cnt;

   logic x;
   logic y;
   logic d;
   logic brn;

   // Full-subtractor cell on the current operand LSBs.
   always_comb begin
      x   = sa[0];
      y   = sb[0];
      d   = x ^ y ^ br;
      brn = (~x & y) | (~(x ^ y) & br);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         sr     <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         differ <= '0;
         barrow <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  sr    <= '0;
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            SHIFT: begin
               sr <= {d, sr[WIDTH-1:1]};
               sa <= {1'b0, sa[WIDTH-1:1]};
               sb <= {1'b0, sb[WIDTH-1:1]};
               br <= brn;
               if (cnt == LAST) begin
                  // Final bit lands directly in the result, LSB-aligned.
                  differ <= {d, sr[WIDTH-1:1]};
                  barrow <= brn;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  cnt    <= '0;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: reference is {borrow, diff} = {0,a} - {0,b}.
// Expected results are queued on each accept and popped by a done monitor.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] differ;
   logic         barrow;

   typedef struct {
      logic [W-1:0] diff;
      logic         bor;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int   nvec;
   int   nmis;
   int   cyc;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .differ (differ),
      .barrow (barrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: plain unsigned arithmetic on widened operands.
   function automatic exp_t model(input logic [W-1:0] ma,
                                  input logic [W-1:0] mb, input int c);
      exp_t e;
      logic [W:0] r;
      r      = {1'b0, ma} - {1'b0, mb};
      e.diff = r[W-1:0];
      e.bor  = r[W];
      e.cyc  = c + W;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done && busy) chk("done_and_busy", 1, 0);
         if (done) begin
            if (q.size() == 0) begin
               chk("spurious_done", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("differ", differ, e.diff);
               chk("barrow", barrow, e.bor);
               chk("latency", cyc, e.cyc);
            end
         end
      end
   end

   task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob);
      @(negedge clk);
      a     = oa;
      b     = ob;
      start = 1'b1;
      @(posedge clk);
      #1;
      q.push_back(model(oa, ob, cyc));
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         chk("busy_shift", busy, 1);
      end
      @(negedge clk);
      chk("busy_done", busy, 0);
      #1;
      chk("result_seen", q.size(), 0);
      q.delete();
   endtask

   initial begin
      logic [W-1:0] va[6];
      logic [W-1:0] vb[6];
      nvec  = 0;
      nmis  = 0;
      cyc   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      va = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'hA5, 8'h80};
      vb = '{8'h03, 8'h05, 8'h01, 8'h00, 8'hA5, 8'h7F};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_differ", differ, 0);
      chk("rst_barrow", barrow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      for (int i = 0; i < 6; i++) op(va[i], vb[i]);

      // Start raised mid-SHIFT must be ignored.
      @(negedge clk);
      a = 8'h10;
      b = 8'h01;
      start = 1'b1;
      @(posedge clk);
      #1;
      q.push_back(model(8'h10, 8'h01, cyc));
      start = 1'b0;
      repeat (3) @(negedge clk);
      a = 8'h00;
      b = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (W + 4) @(negedge clk);
      #1;
      chk("busy_ignore_q", q.size(), 0);
      chk("busy_ignore_idle", busy, 0);

      // Back-to-back with start held high.
      @(negedge clk);
      a = W'($urandom);
      b = W'($urandom);
      start = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         #1;
         q.push_back(model(a, b, cyc));
         a = W'($urandom);
         b = W'($urandom);
         for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            chk("b2b_busy_xor_done", busy ^ done, 1);
            if (n == 5 && i == W) start = 1'b0;
         end
      end
      repeat (2) @(negedge clk);
      #1;
      chk("b2b_q", q.size(), 0);

      // Reset in the middle of SHIFT aborts without a done pulse.
      @(negedge clk);
      a = 8'h33;
      b = 8'h11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_differ", differ, 0);
      chk("abort_barrow", barrow, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 2) @(negedge clk);
      chk("abort_quiet", done, 0);
      op(8'h09, 8'h04);

      for (int i = 0; i < 40; i++) op(W'($urandom), W'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
